// File: rtl/kernel_status_pio.sv
// kernel_status_pio: Avalon-MM input PIO for the CNN kernel status lines.
// Synchronizes in_port, latches per-bit edges into a sticky write-1-to-clear
// register and raises a maskable level interrupt for the Nios II.
//
// Bus handshake: Avalon-MM slave with no wait states. A write is accepted on
// any clk edge where chipselect=1 and write_n=0. readdata is reloaded on every
// clk edge from the register selected by address, so read data is valid one
// cycle after address is presented. Reads have no side effects.

`timescale 1ns/1ps

module kernel_status_pio #(
   parameter int WIDTH       = 8,  // number of status inputs, 1..32
   parameter int EDGE_TYPE   = 0,  // 0 = rising, 1 = falling, 2 = any
   parameter int SYNC_STAGES = 2   // synchronizer depth, 2..4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_CAPT = 2'd3;

   logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] edges;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] mask_next;
   logic [WIDTH-1:0] capture_clr;
   logic [WIDTH-1:0] capture_next;
   logic [31:0]      rd_word;
   logic             wr_en;
   logic             unused_wdata;

   // Bits of writedata above WIDTH-1 carry no meaning for this block.
   assign unused_wdata = ^writedata;

   assign wr_en = chipselect & ~write_n;
   assign sync  = sync_chain[SYNC_STAGES-1];

   // Metastability chain on the asynchronous kernel status lines.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_chain[i] <= '0;
         end
      end else begin
         sync_chain[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_chain[i] <= sync_chain[i-1];
         end
      end
   end

   // One-cycle delayed copy of the synchronized inputs for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev <= '0;
      end else begin
         prev <= sync;
      end
   end

   // Edge polarity is fixed at elaboration time.
   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign edges = sync & ~prev;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign edges = ~sync & prev;
      end else begin : g_any
         assign edges = sync ^ prev;
      end
   endgenerate

   // Next-state of mask and capture; a new edge beats a same-cycle clear.
   always_comb begin
      mask_next   = irq_mask;
      capture_clr = '0;
      if (wr_en && (address == ADDR_MASK)) begin
         mask_next = writedata[WIDTH-1:0];
      end
      if (wr_en && (address == ADDR_CAPT)) begin
         capture_clr = writedata[WIDTH-1:0];
      end
      capture_next = (edge_capture & ~capture_clr) | edges;
   end

   // Mask, sticky capture and the registered interrupt. irq is computed from
   // the next-state values so it changes on the same edge as its sources.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask     <= '0;
         edge_capture <= '0;
         irq          <= 1'b0;
      end else begin
         irq_mask     <= mask_next;
         edge_capture <= capture_next;
         irq          <= |(capture_next & mask_next);
      end
   end

   // Read mux; unused upper bits stay zero.
   always_comb begin
      rd_word = '0;
      case (address)
         ADDR_DATA: rd_word[WIDTH-1:0] = sync;
         ADDR_RSVD: rd_word = '0;
         ADDR_MASK: rd_word[WIDTH-1:0] = irq_mask;
         ADDR_CAPT: rd_word[WIDTH-1:0] = edge_capture;
         default:   rd_word = '0;
      endcase
   end

   // Registered read data, loaded every edge (latency 1, no wait states).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_word;
      end
   end

endmodule

// File: tb/tb_kernel_status_pio.sv
// Directed testbench for kernel_status_pio. A rising-edge instance and an
// any-edge instance share the bus and in_port; checks are immediate assertions.

`timescale 1ns/1ps

module tb_kernel_status_pio;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [31:0] readdata_any;
   logic [7:0]  in_port;
   logic        irq;
   logic        irq_any;

   int n_checks = 0;
   int n_fail   = 0;

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected end before 200000ns");
      $fatal(1, "watchdog expired");
   end

   kernel_status_pio #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   kernel_status_pio #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata_any),
      .in_port    (in_port),
      .irq        (irq_any)
   );

   // Driver tasks
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic bus_read(input logic [1:0] a);
      address    = a;
      chipselect = 1'b1;
      tick(1);
      chipselect = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Directed sequence
   initial begin
      reset_n    = 1'b0;
      in_port    = 8'hFF;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;

      // Reset: everything reads 0 while reset_n is low.
      tick(2);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_irq_any", 32'(irq_any), 32'h0);
      check("rst_readdata", readdata, 32'h0);
      for (int a = 0; a < 4; a++) begin
         bus_read(2'(a));
         check("rst_read", readdata, 32'h0);
      end

      // Release with inputs high: capture sets on the third edge after release.
      reset_n = 1'b1;
      tick(2);
      bus_read(2'd3);
      check("rst_artifact_early", readdata, 32'h0);
      bus_read(2'd3);
      check("rst_artifact", readdata, 32'h0000_00FF);
      check("rst_artifact_irq", 32'(irq), 32'h0);
      bus_write(2'd3, 32'h0000_00FF);
      bus_read(2'd3);
      check("rst_artifact_clr", readdata, 32'h0);

      // Capture and interrupt on bit 0.
      bus_write(2'd2, 32'h0000_0001);
      in_port = 8'h00;
      tick(4);
      bus_read(2'd3);
      check("fall_ignored", readdata, 32'h0);
      address    = 2'd3;
      chipselect = 1'b1;
      in_port    = 8'h01;
      tick(1);
      check("irq_e0", 32'(irq), 32'h0);
      tick(1);
      check("irq_e0p1", 32'(irq), 32'h0);
      tick(1);
      check("irq_e0p2", 32'(irq), 32'h1);
      check("capt_rd_latency", readdata, 32'h0);
      tick(1);
      check("capt_bit0", readdata, 32'h0000_0001);
      chipselect = 1'b0;
      bus_read(2'd0);
      check("data_live", readdata, 32'h0000_0001);
      bus_read(2'd2);
      check("mask_rb", readdata, 32'h0000_0001);
      bus_write(2'd3, 32'h0000_0001);
      check("irq_clr", 32'(irq), 32'h0);
      in_port = 8'h00;
      tick(4);
      bus_read(2'd3);
      check("fall_no_capture", readdata, 32'h0);
      check("fall_no_irq", 32'(irq), 32'h0);

      // Masked edge on bit 3, then unmask.
      bus_write(2'd2, 32'h0);
      in_port = 8'h08;
      tick(2);
      in_port = 8'h00;
      tick(4);
      bus_read(2'd3);
      check("masked_capt", readdata, 32'h0000_0008);
      check("masked_irq", 32'(irq), 32'h0);
      bus_write(2'd2, 32'h0000_0008);
      check("irq_unmask", 32'(irq), 32'h1);
      bus_write(2'd3, 32'h0000_0008);
      check("irq_unmask_clr", 32'(irq), 32'h0);

      // Write-1-to-clear and set/clear collision.
      in_port = 8'h06;
      tick(4);
      in_port = 8'h00;
      tick(4);
      bus_read(2'd3);
      check("w1c_pre", readdata, 32'h0000_0006);
      bus_write(2'd3, 32'h0000_0002);
      bus_read(2'd3);
      check("w1c_partial", readdata, 32'h0000_0004);
      in_port = 8'h02;
      tick(2);
      bus_write(2'd3, 32'h0000_0002);
      bus_read(2'd3);
      check("collision_set_wins", readdata, 32'h0000_0006);
      bus_write(2'd3, 32'h0000_0006);
      bus_read(2'd3);
      check("w1c_all", readdata, 32'h0);

      // Any-edge instance: fall and rise on bit 5 each captured.
      in_port = 8'h20;
      tick(4);
      bus_write(2'd3, 32'h0000_00FF);
      bus_read(2'd3);
      check("any_clear0", readdata_any, 32'h0);
      in_port = 8'h00;
      tick(4);
      bus_read(2'd3);
      check("any_fall", readdata_any, 32'h0000_0020);
      check("rise_only_fall", readdata, 32'h0);
      bus_write(2'd3, 32'h0000_0020);
      bus_read(2'd3);
      check("any_clear1", readdata_any, 32'h0);
      in_port = 8'h20;
      tick(4);
      bus_read(2'd3);
      check("any_rise", readdata_any, 32'h0000_0020);
      check("rise_only_rise", readdata, 32'h0000_0020);
      bus_write(2'd3, 32'h0000_0020);

      // Read-only and reserved addresses ignore writes; upper bits read 0.
      bus_write(2'd0, 32'hFFFF_FFFF);
      bus_write(2'd1, 32'hFFFF_FFFF);
      bus_read(2'd1);
      check("rsvd_zero", readdata, 32'h0);
      bus_read(2'd0);
      check("data_ro", readdata, 32'h0000_0020);
      bus_write(2'd2, 32'hFFFF_FFFF);
      bus_read(2'd2);
      check("mask_upper_zero", readdata, 32'h0000_00FF);

      // Reset mid-operation with irq asserted.
      in_port = 8'h00;
      tick(4);
      bus_write(2'd3, 32'h0000_00FF);
      bus_write(2'd2, 32'h0000_00F0);
      in_port = 8'hF0;
      tick(4);
      bus_read(2'd3);
      check("mid_capt", readdata, 32'h0000_00F0);
      check("mid_irq", 32'(irq), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check("irq_async", 32'(irq), 32'h0);
      check("readdata_async", readdata, 32'h0);
      in_port = 8'h00;
      tick(2);
      reset_n = 1'b1;
      tick(4);
      for (int a = 0; a < 4; a++) begin
         bus_read(2'(a));
         check("post_rst_read", readdata, 32'h0);
      end
      check("post_rst_irq", 32'(irq), 32'h0);

      // Final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
